// File: rtl/time_display_scan.sv
// Display scanner for the countdown counter. Shows " A.BC" on a 4-digit
// multiplexed common-anode 7-segment display. Slow-domain digits are
// filtered for two-sample stability before use. Blinks at zero and flags
// time_up.
module time_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit_a,
  input  logic [3:0] digit_b,
  input  logic [3:0] digit_c,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       time_up
);

  localparam int NUM_DIG = 3;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Digit order inside the packed arrays: [2]=a (minutes), [1]=b, [0]=c.
  logic [NUM_DIG-1:0][3:0] s1, s2, held;
  logic [NUM_DIG-1:0][6:0] held_seg;
  logic                    valid;

  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [1:0]    idx;
  logic [BW-1:0] bl_cnt;
  logic          phase_on;

  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b0111111;  // out-of-range digit shows a dash
    endcase
  endfunction

  // One encoder per held digit.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_enc
    assign held_seg[g] = enc(held[g]);
  end

  // Two-stage sampling; held only updates on two equal consecutive samples,
  // so a one-cycle glitch from the slow domain is dropped.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      held  <= '0;
      valid <= 1'b0;
    end else begin
      s1 <= {digit_a, digit_b, digit_c};
      s2 <= s1;
      if (s2 == s1) begin
        held  <= s2;
        valid <= 1'b1;
      end
    end
  end

  assign tick = enable && (ps_cnt == PS_LAST);

  // Slot-rate prescaler; parked at 0 while disabled so a re-enable gets a full slot.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)                ps_cnt <= '0;
    else if (!enable || tick)  ps_cnt <= '0;
    else                       ps_cnt <= ps_cnt + PW'(1);
  end

  // Scan position, advancing one digit slot per tick.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)       idx <= SLOT0;
    else if (!enable) idx <= SLOT0;
    else if (tick)    idx <= idx + 2'd1;
  end

  // Zero detect on the accepted digits.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) time_up <= 1'b0;
    else        time_up <= valid & enable & (held == '0);
  end

  // Blink phase: counts slots while time is up, toggling every BLINK_DIV slots.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      bl_cnt   <= '0;
      phase_on <= 1'b1;
    end else if (!enable || !time_up) begin
      bl_cnt   <= '0;
      phase_on <= 1'b1;
    end else if (tick) begin
      if (bl_cnt == BL_LAST) begin
        bl_cnt   <= '0;
        phase_on <= ~phase_on;
      end else begin
        bl_cnt <= bl_cnt + BW'(1);
      end
    end
  end

  // Next drive for the current slot; disabled or not-yet-valid blanks everything.
  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    case (idx)
      SLOT0: begin an_d = 4'b1110; seg_d = held_seg[0]; end
      SLOT1: begin an_d = 4'b1101; seg_d = held_seg[1]; end
      SLOT2: begin an_d = 4'b1011; seg_d = held_seg[2]; dp_d = 1'b0; end
      SLOT3: ;
      default: ;
    endcase
    if (!enable || !valid) begin
      an_d  = 4'hF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else if (!phase_on) begin
      an_d = 4'hF;
      dp_d = 1'b1;
    end
  end

  // Registered display drive, one clk behind idx.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      an  <= 4'hF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan (REFRESH_DIV=4, BLINK_DIV=2).
// Stimulus pushes hand-computed per-cycle display expectations; a negedge
// monitor pops and compares them as the cycle counter reaches each entry.
module tb_time_display_scan;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] digit_a = 4'd0, digit_b = 4'd0, digit_c = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       time_up;

  time_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable),
    .digit_a(digit_a), .digit_b(digit_b), .digit_c(digit_c),
    .an(an), .seg(seg), .dp(dp), .time_up(time_up)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010, S9 = 7'b0010000, SD = 7'b0111111;
  localparam logic [6:0] SB = 7'h7F;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tu;
    logic       chk_seg;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   n0    = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [3:0] ea, input logic [6:0] es,
                       input logic ed, input logic et, input logic cs);
    total++;
    if (an !== ea || (cs && seg !== es) || dp !== ed || time_up !== et) begin
      bad++;
      $display("FAIL %s cyc=%0d an=%b want %b seg=%b want %b dp=%b want %b time_up=%b want %b",
               nm, cyc, an, ea, seg, es, dp, ed, time_up, et);
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk_in) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s missed cyc=%0d now %0d", e.nm, e.cyc, cyc);
      end else begin
        check(e.nm, e.an, e.seg, e.dp, e.tu, e.chk_seg);
      end
    end
  end

  task automatic ex(input int c, input logic [3:0] a_, input logic [6:0] s_,
                    input logic d_, input logic t_, input logic cs, input string nm);
    exp_t e;
    e = '{cyc: c, an: a_, seg: s_, dp: d_, tu: t_, chk_seg: cs, nm: nm};
    q.push_back(e);
  endtask

  // Normal scan expectation for cycles n0+k0..n0+k1; slot from cycles since scan start `st`.
  task automatic scan(input int st, input int k0, input int k1, input logic [6:0] sc,
                      input logic [6:0] sb, input logic [6:0] sa, input logic t_,
                      input string nm);
    for (int k = k0; k <= k1; k++) begin
      case (((k - st - 1) / 4) % 4)
        0:       ex(n0 + k, 4'b1110, sc, 1'b1, t_, 1'b1, nm);
        1:       ex(n0 + k, 4'b1101, sb, 1'b1, t_, 1'b1, nm);
        2:       ex(n0 + k, 4'b1011, sa, 1'b0, t_, 1'b1, nm);
        default: ex(n0 + k, 4'b1111, SB, 1'b1, t_, 1'b1, nm);
      endcase
    end
  endtask

  task automatic blank(input int k0, input int k1, input logic t_, input logic cs,
                       input string nm);
    for (int k = k0; k <= k1; k++) ex(n0 + k, 4'b1111, SB, 1'b1, t_, cs, nm);
  endtask

  task automatic go(input int k);
    while (cyc < n0 + k) @(negedge clk_in);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check("reset_init", 4'hF, SB, 1'b1, 1'b0, 1'b1);
    digit_a = 4'd2; digit_b = 4'd5; digit_c = 4'd9;
    repeat (2) @(negedge clk_in);
    check("reset_held", 4'hF, SB, 1'b1, 1'b0, 1'b1);

    // Release with enable low: digits captured, display stays blank.
    reset = 1'b1;
    n0 = cyc;
    blank(1, 4, 1'b0, 1'b1, "disabled_blank");
    go(4);

    // Scan of 2.59 with a one-cycle glitch on c in the middle.
    n0 = cyc;
    enable = 1'b1;
    scan(0, 1, 32, S9, S5, S2, 1'b0, "scan_259");
    go(16); digit_c = 4'd3;
    go(17); digit_c = 4'd9;
    go(32);

    // Zero: time_up, then blink 2 slots on / 2 off; then c=1 stops it.
    digit_a = 4'd0; digit_b = 4'd0; digit_c = 4'd0;
    scan(0, 33, 35, S9, S0, S0, 1'b0, "zero_pre");
    scan(0, 36, 44, S0, S0, S0, 1'b1, "zero_on");
    blank(45, 52, 1'b1, 1'b0, "blink_off");
    scan(0, 53, 60, S0, S0, S0, 1'b1, "blink_on");
    blank(61, 65, 1'b1, 1'b0, "blink_off2");
    blank(66, 67, 1'b0, 1'b0, "tu_fall");
    scan(0, 68, 76, S1, S0, S0, 1'b0, "blink_stop");
    go(62); digit_c = 4'd1;
    go(76);

    // Out-of-range seconds digit shows a dash.
    digit_a = 4'd2; digit_b = 4'd5; digit_c = 4'hC;
    scan(0, 77, 90, SD, S5, S2, 1'b0, "dash");
    go(90);

    // Disable during slot 2, re-enable restarts at slot 0 for a full slot.
    enable = 1'b0;
    blank(91, 93, 1'b0, 1'b1, "en_drop");
    scan(93, 94, 99, SD, S5, S2, 1'b0, "en_restart");
    go(93); enable = 1'b1;
    go(99);

    // Async reset mid-slot 1, no clock edge in between.
    #2 reset = 1'b0;
    #1 check("async_reset", 4'hF, SB, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
